idex_execute_unit: RTL and testbench

IDEX_EXECUTE_UNIT -- requirements
Module: idex_execute_unit

---
 rtl/idex_execute_pkg.sv | 32 +++
 rtl/idex_execute_unit_if.sv | 61 ++++++
 rtl/idex_execute_unit_ex_alu.sv | 36 +++
 rtl/idex_execute_unit.sv | 121 ++++++++++++
 tb/tb_idex_execute_unit.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/idex_execute_pkg.sv
// rtl/idex_execute_pkg.sv - shared encodings for the ID/EX execute slice
package idex_execute_pkg;

   localparam int XLEN_DEFAULT = 64;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_XOR  = 4'b0011,
      ALU_SLL  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_SUB  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_SLTU = 4'b1001
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      ALUOP_ADD     = 2'b00,
      ALUOP_SUB     = 2'b01,
      ALUOP_FUNCT   = 2'b10,
      ALUOP_ADD_ALT = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_NONE  = 2'b00,
      FWD_MEMWB = 2'b01,
      FWD_EXMEM = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/idex_execute_unit_if.sv
// rtl/idex_execute_unit_if.sv - decode-side inputs, forwarding sources and EX results
interface idex_execute_unit_if
   import idex_execute_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
);
   logic            flush;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_rs1_data;
   logic [XLEN-1:0] id_rs2_data;
   logic [4:0]      id_rs1;
   logic [4:0]      id_rs2;
   logic [4:0]      id_rd;
   logic [XLEN-1:0] id_imm;
   logic            id_branch;
   logic            id_mem_read;
   logic            id_mem_to_reg;
   logic            id_mem_write;
   logic            id_alu_src;
   logic            id_reg_write;
   logic [1:0]      id_alu_op;
   logic [2:0]      id_funct3;
   logic            id_funct7b5;
   logic [4:0]      ex_mem_rd;
   logic            ex_mem_reg_write;
   logic [XLEN-1:0] ex_mem_result;
   logic [4:0]      mem_wb_rd;
   logic            mem_wb_reg_write;
   logic [XLEN-1:0] mem_wb_data;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;
   logic [3:0]      alu_ctrl;
   logic [XLEN-1:0] pc_branch;
   logic [XLEN-1:0] store_data;
   logic [1:0]      forward_a;
   logic [1:0]      forward_b;
   logic [4:0]      ex_rd;
   logic            ex_branch;
   logic            ex_mem_read;
   logic            ex_mem_to_reg;
   logic            ex_mem_write;
   logic            ex_reg_write;

   modport master (
      output flush, id_pc, id_rs1_data, id_rs2_data, id_rs1, id_rs2, id_rd, id_imm,
             id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write,
             id_alu_op, id_funct3, id_funct7b5,
             ex_mem_rd, ex_mem_reg_write, ex_mem_result, mem_wb_rd, mem_wb_reg_write, mem_wb_data,
      input  alu_result, alu_zero, alu_ctrl, pc_branch, store_data, forward_a, forward_b,
             ex_rd, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_reg_write
   );

   modport slave (
      input  flush, id_pc, id_rs1_data, id_rs2_data, id_rs1, id_rs2, id_rd, id_imm,
             id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write,
             id_alu_op, id_funct3, id_funct7b5,
             ex_mem_rd, ex_mem_reg_write, ex_mem_result, mem_wb_rd, mem_wb_reg_write, mem_wb_data,
      output alu_result, alu_zero, alu_ctrl, pc_branch, store_data, forward_a, forward_b,
             ex_rd, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_reg_write
   );
endinterface

// File: rtl/idex_execute_unit_ex_alu.sv
// rtl/idex_execute_unit_ex_alu.sv - combinational integer ALU used by the execute stage
module ex_alu
   import idex_execute_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   input  alu_ctrl_e       i_ctrl,
   output logic [XLEN-1:0] o_result,
   output logic            o_zero
);
   logic [5:0] w_shamt;

   assign w_shamt = i_b[5:0];

   // operation select; unused codes yield zero
   always_comb begin
      o_result = '0;
      case (i_ctrl)
         ALU_AND:  o_result = i_a & i_b;
         ALU_OR:   o_result = i_a | i_b;
         ALU_ADD:  o_result = i_a + i_b;
         ALU_XOR:  o_result = i_a ^ i_b;
         ALU_SLL:  o_result = i_a << w_shamt;
         ALU_SRL:  o_result = i_a >> w_shamt;
         ALU_SUB:  o_result = i_a - i_b;
         ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
         ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
         default:  o_result = '0;
      endcase
   end

   assign o_zero = (o_result == '0);
endmodule

// File: rtl/idex_execute_unit.sv
// rtl/idex_execute_unit.sv - ID/EX register, forwarding and ALU control; forwarding built only with IDEX_FWD_EN
module idex_execute_unit
   import idex_execute_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input logic                clk,
   input logic                rst,
   idex_execute_unit_if.slave bus
);
   logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
   logic [4:0]      r_rs1, r_rs2, r_rd;
   logic            r_branch, r_mem_read, r_mem_to_reg, r_mem_write, r_alu_src, r_reg_write;
   logic [1:0]      r_alu_op;
   logic [2:0]      r_funct3;
   logic            r_funct7b5;

   fwd_sel_e        w_fwd_a, w_fwd_b;
   logic [XLEN-1:0] w_op_a, w_store, w_op_b, w_alu_result;
   logic            w_alu_zero;
   alu_ctrl_e       w_alu_ctrl;

   // ID/EX pipeline register; flush turns the slot into an all-zero bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst || bus.flush) begin
         r_pc <= '0;  r_rs1_data <= '0;  r_rs2_data <= '0;  r_imm <= '0;
         r_rs1 <= '0; r_rs2 <= '0;       r_rd <= '0;
         r_branch <= 1'b0; r_mem_read <= 1'b0; r_mem_to_reg <= 1'b0;
         r_mem_write <= 1'b0; r_alu_src <= 1'b0; r_reg_write <= 1'b0;
         r_alu_op <= '0; r_funct3 <= '0; r_funct7b5 <= 1'b0;
      end else begin
         r_pc <= bus.id_pc;   r_rs1_data <= bus.id_rs1_data;
         r_rs2_data <= bus.id_rs2_data;   r_imm <= bus.id_imm;
         r_rs1 <= bus.id_rs1; r_rs2 <= bus.id_rs2; r_rd <= bus.id_rd;
         r_branch <= bus.id_branch;       r_mem_read <= bus.id_mem_read;
         r_mem_to_reg <= bus.id_mem_to_reg; r_mem_write <= bus.id_mem_write;
         r_alu_src <= bus.id_alu_src;     r_reg_write <= bus.id_reg_write;
         r_alu_op <= bus.id_alu_op; r_funct3 <= bus.id_funct3; r_funct7b5 <= bus.id_funct7b5;
      end
   end

`ifdef IDEX_FWD_EN
   // hazard detect: the younger EX/MEM producer wins, x0 is never bypassed
   always_comb begin
      w_fwd_a = FWD_NONE;
      w_fwd_b = FWD_NONE;
      if (bus.ex_mem_reg_write && bus.ex_mem_rd != 5'd0 && bus.ex_mem_rd == r_rs1)
         w_fwd_a = FWD_EXMEM;
      else if (bus.mem_wb_reg_write && bus.mem_wb_rd != 5'd0 && bus.mem_wb_rd == r_rs1)
         w_fwd_a = FWD_MEMWB;
      if (bus.ex_mem_reg_write && bus.ex_mem_rd != 5'd0 && bus.ex_mem_rd == r_rs2)
         w_fwd_b = FWD_EXMEM;
      else if (bus.mem_wb_reg_write && bus.mem_wb_rd != 5'd0 && bus.mem_wb_rd == r_rs2)
         w_fwd_b = FWD_MEMWB;
   end
`else
   assign w_fwd_a = FWD_NONE;
   assign w_fwd_b = FWD_NONE;
`endif

   // operand muxes: bypass sources or the registered register-file values
   always_comb begin
      w_op_a  = r_rs1_data;
      w_store = r_rs2_data;
      case (w_fwd_a)
         FWD_EXMEM: w_op_a = bus.ex_mem_result;
         FWD_MEMWB: w_op_a = bus.mem_wb_data;
         default:   w_op_a = r_rs1_data;
      endcase
      case (w_fwd_b)
         FWD_EXMEM: w_store = bus.ex_mem_result;
         FWD_MEMWB: w_store = bus.mem_wb_data;
         default:   w_store = r_rs2_data;
      endcase
   end

   assign w_op_b = r_alu_src ? r_imm : w_store;

   // ALU control decode from alu_op, funct3 and instruction bit 30
   always_comb begin
      w_alu_ctrl = ALU_ADD;
      case (r_alu_op)
         ALUOP_SUB:   w_alu_ctrl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (r_funct3)
               3'b000:  w_alu_ctrl = (r_funct7b5 && !r_alu_src) ? ALU_SUB : ALU_ADD;
               3'b111:  w_alu_ctrl = ALU_AND;
               3'b110:  w_alu_ctrl = ALU_OR;
               3'b100:  w_alu_ctrl = ALU_XOR;
               3'b001:  w_alu_ctrl = ALU_SLL;
               3'b101:  w_alu_ctrl = r_funct7b5 ? ALU_SRA : ALU_SRL;
               3'b010:  w_alu_ctrl = ALU_SLT;
               default: w_alu_ctrl = ALU_SLTU;
            endcase
         end
         default:     w_alu_ctrl = ALU_ADD;
      endcase
   end

   ex_alu #(.XLEN(XLEN)) u_alu (
      .i_a      (w_op_a),
      .i_b      (w_op_b),
      .i_ctrl   (w_alu_ctrl),
      .o_result (w_alu_result),
      .o_zero   (w_alu_zero)
   );

   assign bus.alu_result    = w_alu_result;
   assign bus.alu_zero      = w_alu_zero;
   assign bus.alu_ctrl      = w_alu_ctrl;
   assign bus.pc_branch     = r_pc + r_imm;
   assign bus.store_data    = w_store;
   assign bus.forward_a     = w_fwd_a;
   assign bus.forward_b     = w_fwd_b;
   assign bus.ex_rd         = r_rd;
   assign bus.ex_branch     = r_branch;
   assign bus.ex_mem_read   = r_mem_read;
   assign bus.ex_mem_to_reg = r_mem_to_reg;
   assign bus.ex_mem_write  = r_mem_write;
   assign bus.ex_reg_write  = r_reg_write;
endmodule

// File: tb/tb_idex_execute_unit.sv
// tb/tb_idex_execute_unit.sv - self-checking bench for idex_execute_unit
module tb_idex_execute_unit;
   localparam int XLEN = 64;

   localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3, OP_XOR = 4,
                  OP_SLL = 5, OP_SRL = 6, OP_SRA = 7, OP_SLT = 8, OP_SLTU = 9;

   typedef struct {
      logic [63:0] pc, rs1d, rs2d, imm;
      logic [4:0]  rs1, rs2, rd;
      logic        br, mr, m2r, mw, as, rw;
      logic [1:0]  op;
      logic [2:0]  f3;
      logic        f7;
   } id_t;

   typedef struct {
      logic [4:0]  xrd;
      logic        xwe;
      logic [63:0] xres;
      logic [4:0]  wrd;
      logic        wwe;
      logic [63:0] wdat;
   } fw_t;

   typedef struct {
      logic [63:0] res, pcb, store;
      logic        zero;
      logic [3:0]  ctrl;
      logic [1:0]  fa, fb;
      logic [4:0]  rd;
      logic        br, mr, m2r, mw, rw;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   idex_execute_unit_if #(.XLEN(XLEN)) bus ();

   idex_execute_unit #(.XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic id_t id_blank();
      id_t t;
      t = '{default: '0};
      return t;
   endfunction

   function automatic fw_t fw_blank();
      fw_t f;
      f = '{default: '0};
      return f;
   endfunction

   function automatic int sel_src(logic [4:0] rs, fw_t f);
      int s;
      s = 0;
`ifdef IDEX_FWD_EN
      if (f.xwe && f.xrd != 0 && f.xrd == rs) s = 2;
      else if (f.wwe && f.wrd != 0 && f.wrd == rs) s = 1;
`endif
      return s;
   endfunction

   function automatic exp_t model(id_t t, fw_t f);
      exp_t        e;
      int          sa, sb, op;
      logic [63:0] a, s, b, r, fill;
      sa = sel_src(t.rs1, f);
      sb = sel_src(t.rs2, f);
      a  = (sa == 2) ? f.xres : (sa == 1) ? f.wdat : t.rs1d;
      s  = (sb == 2) ? f.xres : (sb == 1) ? f.wdat : t.rs2d;
      b  = t.as ? t.imm : s;
      if (t.op == 2'b01) op = OP_SUB;
      else if (t.op != 2'b10) op = OP_ADD;
      else begin
         case (t.f3)
            3'd0: op = (t.f7 && !t.as) ? OP_SUB : OP_ADD;
            3'd7: op = OP_AND;
            3'd6: op = OP_OR;
            3'd4: op = OP_XOR;
            3'd1: op = OP_SLL;
            3'd5: op = t.f7 ? OP_SRA : OP_SRL;
            3'd2: op = OP_SLT;
            default: op = OP_SLTU;
         endcase
      end
      fill = a[63] ? ~({64{1'b1}} >> b[5:0]) : 64'd0;
      case (op)
         OP_ADD:  begin r = a + b; e.ctrl = 4'b0010; end
         OP_SUB:  begin r = a - b; e.ctrl = 4'b0110; end
         OP_AND:  begin r = a & b; e.ctrl = 4'b0000; end
         OP_OR:   begin r = a | b; e.ctrl = 4'b0001; end
         OP_XOR:  begin r = a ^ b; e.ctrl = 4'b0011; end
         OP_SLL:  begin r = a << b[5:0]; e.ctrl = 4'b0100; end
         OP_SRL:  begin r = a >> b[5:0]; e.ctrl = 4'b0101; end
         OP_SRA:  begin r = (a >> b[5:0]) | fill; e.ctrl = 4'b0111; end
         OP_SLT:  begin r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0; e.ctrl = 4'b1000; end
         default: begin r = (a < b) ? 64'd1 : 64'd0; e.ctrl = 4'b1001; end
      endcase
      e.res   = r;
      e.zero  = (r == 0);
      e.pcb   = t.pc + t.imm;
      e.store = s;
      e.fa    = sa[1:0];
      e.fb    = sb[1:0];
      e.rd    = t.rd;
      e.br    = t.br;  e.mr = t.mr;  e.m2r = t.m2r;  e.mw = t.mw;  e.rw = t.rw;
      return e;
   endfunction

   task automatic drive(input id_t t, input fw_t f, input logic fl);
      bus.flush = fl;
      bus.id_pc = t.pc;  bus.id_rs1_data = t.rs1d;  bus.id_rs2_data = t.rs2d;  bus.id_imm = t.imm;
      bus.id_rs1 = t.rs1;  bus.id_rs2 = t.rs2;  bus.id_rd = t.rd;
      bus.id_branch = t.br;  bus.id_mem_read = t.mr;  bus.id_mem_to_reg = t.m2r;
      bus.id_mem_write = t.mw;  bus.id_alu_src = t.as;  bus.id_reg_write = t.rw;
      bus.id_alu_op = t.op;  bus.id_funct3 = t.f3;  bus.id_funct7b5 = t.f7;
      bus.ex_mem_rd = f.xrd;  bus.ex_mem_reg_write = f.xwe;  bus.ex_mem_result = f.xres;
      bus.mem_wb_rd = f.wrd;  bus.mem_wb_reg_write = f.wwe;  bus.mem_wb_data = f.wdat;
   endtask

   task automatic step(input id_t t, input fw_t f, input logic fl);
      @(negedge clk);
      drive(t, f, fl);
      @(posedge clk);
      #1;
   endtask

   function automatic id_t rand_id();
      id_t t;
      t.pc = {$urandom, $urandom};  t.rs1d = {$urandom, $urandom};  t.rs2d = {$urandom, $urandom};
      t.imm = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($signed($urandom_range(0, 4095)) - 2048);
      if ($urandom_range(0, 4) == 0) t.rs2d = {58'd0, 6'($urandom)};
      t.rs1 = 5'($urandom_range(0, 7));  t.rs2 = 5'($urandom_range(0, 7));  t.rd = 5'($urandom);
      t.br = 1'($urandom);  t.mr = 1'($urandom);  t.m2r = 1'($urandom);
      t.mw = 1'($urandom);  t.as = 1'($urandom);  t.rw = 1'($urandom);
      t.op = 2'($urandom);  t.f3 = 3'($urandom);  t.f7 = 1'($urandom);
      return t;
   endfunction

   task automatic test_reset();
      id_t t;
      t = rand_id();
      t.rs1 = 5'd3;  t.rw = 1'b1;  t.mw = 1'b1;  t.br = 1'b1;
      rst = 1'b1;
      drive(t, fw_blank(), 1'b1);
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (bus.alu_result !== 64'd0) begin n_err++; $display("FAIL rst_alu_result got %h exp 0", bus.alu_result); end
      n_vec++; if (bus.alu_zero !== 1'b1) begin n_err++; $display("FAIL rst_alu_zero got %b exp 1", bus.alu_zero); end
      n_vec++; if (bus.pc_branch !== 64'd0) begin n_err++; $display("FAIL rst_pc_branch got %h exp 0", bus.pc_branch); end
      n_vec++; if (bus.store_data !== 64'd0) begin n_err++; $display("FAIL rst_store_data got %h exp 0", bus.store_data); end
      n_vec++; if (bus.alu_ctrl !== 4'b0010) begin n_err++; $display("FAIL rst_alu_ctrl got %b exp 0010", bus.alu_ctrl); end
      n_vec++; if ({bus.forward_a, bus.forward_b} !== 4'b0000) begin n_err++; $display("FAIL rst_forward got %b exp 0000", {bus.forward_a, bus.forward_b}); end
      n_vec++; if ({bus.ex_rd, bus.ex_branch, bus.ex_mem_read, bus.ex_mem_to_reg, bus.ex_mem_write, bus.ex_reg_write} !== 10'd0) begin
         n_err++; $display("FAIL rst_ex_ctrl got %h exp 0", {bus.ex_rd, bus.ex_branch, bus.ex_mem_read, bus.ex_mem_to_reg, bus.ex_mem_write, bus.ex_reg_write}); end
      @(negedge clk);
      rst = 1'b0;
      bus.flush = 1'b0;
      #1;
      n_vec++; if (bus.ex_reg_write !== 1'b0) begin n_err++; $display("FAIL rst_release_early got %b exp 0", bus.ex_reg_write); end
      @(posedge clk);
      #1;
      n_vec++; if (bus.pc_branch !== model(t, fw_blank()).pcb) begin n_err++; $display("FAIL rst_first_capture got %h exp %h", bus.pc_branch, model(t, fw_blank()).pcb); end
      step(t, fw_blank(), 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_vec++; if ({bus.ex_reg_write, bus.ex_mem_write, bus.pc_branch} !== 66'd0) begin
         n_err++; $display("FAIL rst_async_mid got %h exp 0", {bus.ex_reg_write, bus.ex_mem_write, bus.pc_branch}); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_sub();
      id_t t;
      t = id_blank();
      t.rs1 = 5'd1;  t.rs2 = 5'd2;  t.rs1d = 64'd10;  t.rs2d = 64'd3;
      t.op = 2'b10;  t.f3 = 3'b000;  t.f7 = 1'b1;  t.as = 1'b0;
      step(t, fw_blank(), 1'b0);
      n_vec++; if (bus.alu_result !== 64'd7) begin n_err++; $display("FAIL sub_result got %0d exp 7", bus.alu_result); end
      n_vec++; if (bus.alu_ctrl !== 4'b0110) begin n_err++; $display("FAIL sub_ctrl got %b exp 0110", bus.alu_ctrl); end
   endtask

   task automatic test_load_branch();
      id_t t;
      t = id_blank();
      t.op = 2'b00;  t.as = 1'b1;  t.rs1d = 64'd100;  t.imm = -64'sd8;  t.mr = 1'b1;
      step(t, fw_blank(), 1'b0);
      n_vec++; if (bus.alu_result !== 64'd92) begin n_err++; $display("FAIL load_addr got %0d exp 92", bus.alu_result); end
      t = id_blank();
      t.op = 2'b01;  t.rs1d = 64'd5;  t.rs2d = 64'd5;  t.pc = 64'h40;  t.imm = 64'd16;  t.br = 1'b1;
      step(t, fw_blank(), 1'b0);
      n_vec++; if (bus.alu_zero !== 1'b1) begin n_err++; $display("FAIL beq_zero got %b exp 1", bus.alu_zero); end
      n_vec++; if (bus.pc_branch !== 64'h50) begin n_err++; $display("FAIL beq_target got %h exp 50", bus.pc_branch); end
      n_vec++; if (bus.ex_branch !== 1'b1) begin n_err++; $display("FAIL beq_ex_branch got %b exp 1", bus.ex_branch); end
   endtask

   task automatic test_forwarding();
      id_t t;
      fw_t f;
      logic [1:0]  e_fa;
      logic [63:0] e_res;
      t = id_blank();
      t.rs1 = 5'd5;  t.rs1d = 64'd1234;  t.as = 1'b1;  t.imm = 64'd0;
      f.xrd = 5'd5;  f.xwe = 1'b1;  f.xres = 64'd42;  f.wrd = 5'd5;  f.wwe = 1'b1;  f.wdat = 64'd9;
      step(t, f, 1'b0);
`ifdef IDEX_FWD_EN
      e_fa = 2'b10;  e_res = 64'd42;
`else
      e_fa = 2'b00;  e_res = 64'd1234;
`endif
      n_vec++; if (bus.forward_a !== e_fa) begin n_err++; $display("FAIL fwd_exmem_sel got %b exp %b", bus.forward_a, e_fa); end
      n_vec++; if (bus.alu_result !== e_res) begin n_err++; $display("FAIL fwd_exmem_val got %0d exp %0d", bus.alu_result, e_res); end
      f.xwe = 1'b0;
      bus.ex_mem_reg_write = 1'b0;
      #1;
`ifdef IDEX_FWD_EN
      e_fa = 2'b01;  e_res = 64'd9;
`endif
      n_vec++; if (bus.forward_a !== e_fa) begin n_err++; $display("FAIL fwd_memwb_sel got %b exp %b", bus.forward_a, e_fa); end
      n_vec++; if (bus.alu_result !== e_res) begin n_err++; $display("FAIL fwd_memwb_val got %0d exp %0d", bus.alu_result, e_res); end
      t.rs1 = 5'd0;
      f.xrd = 5'd0;  f.xwe = 1'b1;  f.wrd = 5'd0;
      step(t, f, 1'b0);
      n_vec++; if (bus.forward_a !== 2'b00) begin n_err++; $display("FAIL fwd_x0_sel got %b exp 00", bus.forward_a); end
      n_vec++; if (bus.alu_result !== 64'd1234) begin n_err++; $display("FAIL fwd_x0_val got %0d exp 1234", bus.alu_result); end
   endtask

   task automatic test_flush();
      id_t t;
      t = rand_id();
      t.rw = 1'b1;  t.mw = 1'b1;  t.rs1d = 64'd55;  t.imm = 64'd3;  t.as = 1'b1;  t.op = 2'b00;
      step(t, fw_blank(), 1'b1);
      n_vec++; if (bus.ex_reg_write !== 1'b0) begin n_err++; $display("FAIL flush_reg_write got %b exp 0", bus.ex_reg_write); end
      n_vec++; if (bus.ex_mem_write !== 1'b0) begin n_err++; $display("FAIL flush_mem_write got %b exp 0", bus.ex_mem_write); end
      n_vec++; if (bus.alu_result !== 64'd0) begin n_err++; $display("FAIL flush_result got %h exp 0", bus.alu_result); end
   endtask

   task automatic test_signed();
      id_t         t;
      logic [2:0]  f3s[4];
      logic        f7s[4];
      logic [63:0] exps[4];
      f3s = '{3'b010, 3'b011, 3'b101, 3'b101};
      f7s = '{1'b0, 1'b0, 1'b1, 1'b0};
      exps = '{64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h7FFF_FFFF_FFFF_FFFE};
      for (int i = 0; i < 4; i++) begin
         t = id_blank();
         t.rs1 = 5'd1;  t.rs2 = 5'd2;  t.rs1d = -64'sd4;  t.rs2d = 64'd1;
         t.op = 2'b10;  t.f3 = f3s[i];  t.f7 = f7s[i];
         step(t, fw_blank(), 1'b0);
         n_vec++; if (bus.alu_result !== exps[i]) begin n_err++; $display("FAIL signed_op%0d got %h exp %h", i, bus.alu_result, exps[i]); end
      end
   endtask

   task automatic test_back_to_back();
      id_t  a, b;
      exp_t ea;
      a = rand_id();
      b = rand_id();
      b.pc = ~a.pc;
      ea = model(a, fw_blank());
      step(a, fw_blank(), 1'b0);
      drive(b, fw_blank(), 1'b0);
      #1;
      n_vec++; if (bus.pc_branch !== ea.pcb) begin n_err++; $display("FAIL b2b_hold got %h exp %h", bus.pc_branch, ea.pcb); end
      n_vec++; if (bus.alu_result !== ea.res) begin n_err++; $display("FAIL b2b_hold_res got %h exp %h", bus.alu_result, ea.res); end
   endtask

   task automatic test_random();
      id_t  t;
      fw_t  f;
      logic fl;
      exp_t e;
      for (int i = 0; i < 400; i++) begin
         t = rand_id();
         f.xrd = 5'($urandom_range(0, 7));  f.xwe = 1'($urandom);  f.xres = {$urandom, $urandom};
         f.wrd = 5'($urandom_range(0, 7));  f.wwe = 1'($urandom);  f.wdat = {$urandom, $urandom};
         fl = ($urandom_range(0, 9) == 0);
         step(t, f, fl);
         e = model(fl ? id_blank() : t, f);
         n_vec++; if (bus.alu_result !== e.res) begin n_err++; $display("FAIL rnd%0d alu_result got %h exp %h", i, bus.alu_result, e.res); end
         n_vec++; if (bus.alu_zero !== e.zero) begin n_err++; $display("FAIL rnd%0d alu_zero got %b exp %b", i, bus.alu_zero, e.zero); end
         n_vec++; if (bus.alu_ctrl !== e.ctrl) begin n_err++; $display("FAIL rnd%0d alu_ctrl got %b exp %b", i, bus.alu_ctrl, e.ctrl); end
         n_vec++; if (bus.pc_branch !== e.pcb) begin n_err++; $display("FAIL rnd%0d pc_branch got %h exp %h", i, bus.pc_branch, e.pcb); end
         n_vec++; if (bus.store_data !== e.store) begin n_err++; $display("FAIL rnd%0d store_data got %h exp %h", i, bus.store_data, e.store); end
         n_vec++; if (bus.forward_a !== e.fa) begin n_err++; $display("FAIL rnd%0d forward_a got %b exp %b", i, bus.forward_a, e.fa); end
         n_vec++; if (bus.forward_b !== e.fb) begin n_err++; $display("FAIL rnd%0d forward_b got %b exp %b", i, bus.forward_b, e.fb); end
         n_vec++; if ({bus.ex_rd, bus.ex_branch, bus.ex_mem_read, bus.ex_mem_to_reg, bus.ex_mem_write, bus.ex_reg_write}
                      !== {e.rd, e.br, e.mr, e.m2r, e.mw, e.rw}) begin
            n_err++; $display("FAIL rnd%0d ex_ctrl got %h exp %h", i,
               {bus.ex_rd, bus.ex_branch, bus.ex_mem_read, bus.ex_mem_to_reg, bus.ex_mem_write, bus.ex_reg_write},
               {e.rd, e.br, e.mr, e.m2r, e.mw, e.rw});
         end
      end
   endtask

   initial begin
      drive(id_blank(), fw_blank(), 1'b0);
      test_reset();
      test_sub();
      test_load_branch();
      test_forwarding();
      test_flush();
      test_signed();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
